// File: rtl/silencer_settings_loader_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : silencer_settings_loader_pkg
// Brief  : Silencer register map, loader FSM states and settings struct.
// Rev    : 1.0
// ============================================================================
package silencer_settings_loader_pkg;

    localparam int         SILENCER_NUM_REGS                   = 5;
    localparam logic [2:0] ADDR_SILENCER_FLAG                  = 3'd0;
    localparam logic [2:0] ADDR_SILENCER_UPDATE_RATE_INTENSITY = 3'd1;
    localparam logic [2:0] ADDR_SILENCER_UPDATE_RATE_PHASE     = 3'd2;
    localparam logic [2:0] ADDR_SILENCER_COMPLETION_STEPS_INT  = 3'd3;
    localparam logic [2:0] ADDR_SILENCER_COMPLETION_STEPS_PHS  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_CHECK = 2'd3
    } loader_state_t;

    typedef struct packed {
        logic        update;
        logic        mode;
        logic [15:0] update_rate_intensity;
        logic [15:0] update_rate_phase;
        logic [15:0] completion_steps_intensity;
        logic [15:0] completion_steps_phase;
    } silencer_settings_t;

endpackage
`default_nettype wire

// File: rtl/silencer_settings_loader_bram_read_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : bram_read_pipe
// Brief  : Valid/index delay line that tags each BRAM read until its data lands.
// Rev    : 1.0
// ============================================================================
module bram_read_pipe #(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [2:0] in_idx,
    output logic       out_valid,
    output logic [2:0] out_idx
);

    logic [DEPTH-1:0] r_valid;
    logic [2:0]       r_idx [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_idx[i] <= 3'd0;
            end
        end else begin
            r_valid[0] <= in_valid;
            r_idx[0]   <= in_idx;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_valid[i] <= r_valid[i-1];
                r_idx[i]   <= r_idx[i-1];
            end
        end
    end

    assign out_valid = r_valid[DEPTH-1];
    assign out_idx   = r_idx[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/silencer_settings_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : silencer_settings_loader
// Brief  : Reads the five silencer registers, validates them and commits them
//          atomically to the silencer settings struct with a one-cycle UPDATE.
// Rev    : 1.0
// ============================================================================
module silencer_settings_loader
    import silencer_settings_loader_pkg::*;
#(
    parameter int unsigned       ADDR_W        = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR     = 8'h40,
    parameter int unsigned       READ_LATENCY  = 2,
    parameter logic [15:0]       DEF_STEPS_INT = 16'd10,
    parameter logic [15:0]       DEF_STEPS_PHS = 16'd40,
    parameter logic [15:0]       DEF_RATE      = 16'd256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    output logic               bram_en,
    output logic [ADDR_W-1:0]  bram_addr,
    input  logic [15:0]        bram_dout,
    output silencer_settings_t settings,
    output logic               busy,
    output logic               err
);

    loader_state_t      r_state;
    loader_state_t      w_state_next;
    logic [2:0]         r_issue_cnt;
    logic               r_pending;
    logic               r_shadow_mode;
    logic [15:0]        r_shadow_rate_int;
    logic [15:0]        r_shadow_rate_phs;
    logic [15:0]        r_shadow_steps_int;
    logic [15:0]        r_shadow_steps_phs;
    silencer_settings_t r_settings;
    logic               r_err;
    logic               w_cap_valid;
    logic [2:0]         w_cap_idx;
    logic               w_check;
    logic               w_reject;
    logic               w_pend_now;

    bram_read_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bram_en),
        .in_idx    (r_issue_cnt),
        .out_valid (w_cap_valid),
        .out_idx   (w_cap_idx)
    );

    assign bram_en   = (r_state == ST_ISSUE);
    assign bram_addr = BASE_ADDR + ADDR_W'(r_issue_cnt);
    assign settings  = r_settings;
    assign err       = r_err;
    assign busy      = (r_state != ST_IDLE) || r_settings.update || r_err;

    // A request arriving during the CHECK cycle itself still forces a reload.
    assign w_pend_now = r_pending || (req && (r_state != ST_IDLE));
    assign w_reject   = r_shadow_mode ? ((r_shadow_rate_int == 16'd0) || (r_shadow_rate_phs == 16'd0))
                                      : ((r_shadow_steps_int == 16'd0) || (r_shadow_steps_phs == 16'd0));

    always_comb begin
        w_state_next = r_state;
        w_check      = 1'b0;
        case (r_state)
            ST_IDLE:  if (req) w_state_next = ST_ISSUE;
            ST_ISSUE: if (r_issue_cnt == 3'(SILENCER_NUM_REGS - 1)) w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_cap_valid && (w_cap_idx == ADDR_SILENCER_COMPLETION_STEPS_PHS))
                          w_state_next = ST_CHECK;
            ST_CHECK: begin
                w_check      = 1'b1;
                w_state_next = w_pend_now ? ST_ISSUE : ST_IDLE;
            end
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state            <= ST_IDLE;
            r_issue_cnt        <= 3'd0;
            r_pending          <= 1'b0;
            r_shadow_mode      <= 1'b0;
            r_shadow_rate_int  <= 16'd0;
            r_shadow_rate_phs  <= 16'd0;
            r_shadow_steps_int <= 16'd0;
            r_shadow_steps_phs <= 16'd0;
            r_err              <= 1'b0;
            r_settings         <= '{update: 1'b0, mode: 1'b0,
                                    update_rate_intensity: DEF_RATE,
                                    update_rate_phase: DEF_RATE,
                                    completion_steps_intensity: DEF_STEPS_INT,
                                    completion_steps_phase: DEF_STEPS_PHS};
        end else begin
            r_state <= w_state_next;

            if ((r_state != ST_ISSUE) && (w_state_next == ST_ISSUE))
                r_issue_cnt <= 3'd0;
            else if ((r_state == ST_ISSUE) && (r_issue_cnt != 3'(SILENCER_NUM_REGS)))
                r_issue_cnt <= r_issue_cnt + 3'd1;

            if (r_state == ST_CHECK)
                r_pending <= 1'b0;
            else if (req && (r_state != ST_IDLE))
                r_pending <= 1'b1;

            if (w_cap_valid) begin
                case (w_cap_idx)
                    ADDR_SILENCER_FLAG:                  r_shadow_mode      <= bram_dout[0];
                    ADDR_SILENCER_UPDATE_RATE_INTENSITY: r_shadow_rate_int  <= bram_dout;
                    ADDR_SILENCER_UPDATE_RATE_PHASE:     r_shadow_rate_phs  <= bram_dout;
                    ADDR_SILENCER_COMPLETION_STEPS_INT:  r_shadow_steps_int <= bram_dout;
                    ADDR_SILENCER_COMPLETION_STEPS_PHS:  r_shadow_steps_phs <= bram_dout;
                    default: ;
                endcase
            end

            r_err             <= w_check && w_reject;
            r_settings.update <= w_check && !w_reject;
            if (w_check && !w_reject) begin
                r_settings.mode                       <= r_shadow_mode;
                r_settings.update_rate_intensity      <= r_shadow_rate_int;
                r_settings.update_rate_phase          <= r_shadow_rate_phs;
                r_settings.completion_steps_intensity <= r_shadow_steps_int;
                r_settings.completion_steps_phase     <= r_shadow_steps_phs;
            end
        end
    end

endmodule
`default_nettype wire
